// File: rtl/encap_pkg.sv
// Shared types for the encapsulation transmit scheduler: descriptor layout and FSM states.
package encap_pkg;

  typedef struct packed {
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] port;
  } addr_grp_t;

  // MSB-first packing gives {encap, alt_src, alt_dst, src, dst}, each group {mac, ip, port}.
  typedef struct packed {
    logic      encap;
    addr_grp_t alt_src;
    addr_grp_t alt_dst;
    addr_grp_t src;
    addr_grp_t dst;
  } desc_t;

  localparam int unsigned DESC_W = $bits(desc_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } enc_state_t;

endpackage

// File: rtl/encap_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping around.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int unsigned k;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/encap_tx_scheduler.sv
// Shares one encoder between NUM_REQ packet sources: round-robin descriptor grant, header
// handshake, payload pass-through until tlast, and abort forwarding with payload drain.
module encap_tx_scheduler
  import encap_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DESC_W  = encap_pkg::DESC_W,
  localparam int unsigned IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DESC_W-1:0] req_desc,
  input  logic [NUM_REQ-1:0]        req_abort,
  input  logic [NUM_REQ*32-1:0]     s_axis_tdata,
  input  logic [NUM_REQ*4-1:0]      s_axis_tkeep,
  input  logic [NUM_REQ-1:0]        s_axis_tlast,
  input  logic [NUM_REQ-1:0]        s_axis_tvalid,
  output logic [NUM_REQ-1:0]        s_axis_tready,
  output logic [47:0]               enc_dest_addr,
  output logic [31:0]               enc_dest_ip,
  output logic [15:0]               enc_dest_udp_port,
  output logic [47:0]               enc_src_addr,
  output logic [31:0]               enc_src_ip,
  output logic [15:0]               enc_src_udp_port,
  output logic [47:0]               enc_alt_dest_addr,
  output logic [31:0]               enc_alt_dest_ip,
  output logic [15:0]               enc_alt_udp_dest_port,
  output logic [47:0]               enc_alt_src_addr,
  output logic [31:0]               enc_alt_src_ip,
  output logic [15:0]               enc_alt_udp_src_port,
  output logic                      enc_encapsulated,
  output logic                      enc_valid,
  input  logic                      enc_ready,
  output logic                      enc_drop,
  output logic [31:0]               m_axis_tdata,
  output logic [3:0]                m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [IDW-1:0]            grant_id,
  output logic                      busy
);

  enc_state_t           state, next_state;
  logic [IDW-1:0]       rr_ptr;
  desc_t                desc_q;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic                 enc_valid_q;
  logic                 enc_drop_q;
  logic                 set_drop;
  logic                 sel_tready;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDW-1:0]       arb_idx;
  logic                 arb_any;

  logic                 sel_tvalid;
  logic                 sel_tlast;
  logic                 sel_abort;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign sel_tvalid   = s_axis_tvalid[grant_id];
  assign sel_tlast    = s_axis_tlast[grant_id];
  assign sel_abort    = req_abort[grant_id];

  assign m_axis_tdata = s_axis_tdata[grant_id*32 +: 32];
  assign m_axis_tkeep = s_axis_tkeep[grant_id*4 +: 4];
  assign m_axis_tlast = sel_tlast;

  always_comb begin
    next_state    = state;
    set_drop      = 1'b0;
    sel_tready    = 1'b0;
    m_axis_tvalid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_any) next_state = ST_HDR;
      end
      ST_HDR: begin
        if (sel_abort) begin
          set_drop   = 1'b1;
          next_state = ST_DRAIN;
        end else if (enc_valid_q && enc_ready) begin
          next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        sel_tready    = m_axis_tready;
        m_axis_tvalid = sel_tvalid && !sel_abort;
        // The abort-cycle beat is consumed but hidden; its tlast still ends the packet.
        if (sel_abort) begin
          set_drop   = 1'b1;
          next_state = (sel_tvalid && m_axis_tready && sel_tlast) ? ST_IDLE : ST_DRAIN;
        end else if (sel_tvalid && m_axis_tready && sel_tlast) begin
          next_state = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        sel_tready = 1'b1;
        if (sel_tvalid && sel_tlast) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready           = '0;
    s_axis_tready[grant_id] = sel_tready;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      desc_q      <= '0;
      req_ready_q <= '0;
      enc_valid_q <= 1'b0;
      enc_drop_q  <= 1'b0;
    end else begin
      state       <= next_state;
      req_ready_q <= '0;
      // First HDR cycle keeps enc_valid low so it trails the req_ready pulse by one cycle.
      enc_valid_q <= (state == ST_HDR) && (next_state == ST_HDR);
      enc_drop_q  <= set_drop;
      if (state == ST_IDLE && arb_any) begin
        grant_id    <= arb_idx;
        desc_q      <= desc_t'(req_desc[arb_idx*DESC_W +: DESC_W]);
        req_ready_q <= arb_grant;
        rr_ptr      <= (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
      end
    end
  end

  assign req_ready             = req_ready_q;
  assign enc_valid             = enc_valid_q;
  assign enc_drop              = enc_drop_q;
  assign busy                  = (state != ST_IDLE);

  assign enc_dest_addr         = desc_q.dst.mac;
  assign enc_dest_ip           = desc_q.dst.ip;
  assign enc_dest_udp_port     = desc_q.dst.port;
  assign enc_src_addr          = desc_q.src.mac;
  assign enc_src_ip            = desc_q.src.ip;
  assign enc_src_udp_port      = desc_q.src.port;
  assign enc_alt_dest_addr     = desc_q.alt_dst.mac;
  assign enc_alt_dest_ip       = desc_q.alt_dst.ip;
  assign enc_alt_udp_dest_port = desc_q.alt_dst.port;
  assign enc_alt_src_addr      = desc_q.alt_src.mac;
  assign enc_alt_src_ip        = desc_q.alt_src.ip;
  assign enc_alt_udp_src_port  = desc_q.alt_src.port;
  assign enc_encapsulated      = desc_q.encap;

endmodule
